// File: rtl/floating_point_divider_wrapper.sv
// Valid/ready flow-control wrapper around a non-stallable divider pipeline.
// Credits (occupancy) bound issued-plus-buffered work to the result FIFO depth.
module floating_point_divider_wrapper #(
    parameter  int EXP_WIDTH    = 8,
    parameter  int FRAC_WIDTH   = 23,
    parameter  int DEPTH        = 4,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] in_a_i,
    input  logic [FP_WIDTH_REG-1:0] in_b_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [FP_WIDTH_REG-1:0] pipe_a_o,
    output logic [FP_WIDTH_REG-1:0] pipe_b_o,
    output logic                    pipe_valid_o,
    input  logic [FP_WIDTH_REG-1:0] pipe_fp_i,
    input  logic                    pipe_valid_i,
    output logic [FP_WIDTH_REG-1:0] out_fp_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [CNT_WIDTH-1:0]    occupancy_o,
    output logic                    error_o
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);

    logic [FP_WIDTH_REG-1:0] pipe_a_q, pipe_a_d;
    logic [FP_WIDTH_REG-1:0] pipe_b_q, pipe_b_d;
    logic                    pipe_valid_q, pipe_valid_d;
    logic [CNT_WIDTH-1:0]    in_flight_q, in_flight_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic [CNT_WIDTH-1:0]    occupancy_q, occupancy_d;
    logic [PTR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic                    error_q, error_d;
    logic [FP_WIDTH_REG-1:0] mem_q [DEPTH];

    logic accept, ret, pop, wr_en, spurious, overflow;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered credit state and reset, never on out_ready_i.
    assign in_ready_o  = (occupancy_q < DEPTH_C) && !rst_i;
    assign out_valid_o = (count_q != '0);
    assign out_fp_o    = out_valid_o ? mem_q[rd_ptr_q] : '0;

    assign accept   = in_valid_i && in_ready_o;
    assign ret      = pipe_valid_i && (in_flight_q != '0);
    assign pop      = out_valid_o && out_ready_i;
    assign spurious = pipe_valid_i && (in_flight_q == '0);
    assign overflow = ret && (count_q == DEPTH_C) && !pop;
    assign wr_en    = ret && !overflow;

    always_comb begin
        pipe_a_d     = pipe_a_q;
        pipe_b_d     = pipe_b_q;
        pipe_valid_d = accept;
        if (accept) begin
            pipe_a_d = in_a_i;
            pipe_b_d = in_b_i;
        end
        in_flight_d = in_flight_q + CNT_WIDTH'(accept) - CNT_WIDTH'(ret);
        count_d     = count_q + CNT_WIDTH'(wr_en) - CNT_WIDTH'(pop);
        occupancy_d = occupancy_q + CNT_WIDTH'(accept) - CNT_WIDTH'(pop);
        wr_ptr_d    = wr_en ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        error_d     = error_q || spurious || overflow;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_a_q     <= '0;
            pipe_b_q     <= '0;
            pipe_valid_q <= 1'b0;
            in_flight_q  <= '0;
            count_q      <= '0;
            occupancy_q  <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            pipe_a_q     <= pipe_a_d;
            pipe_b_q     <= pipe_b_d;
            pipe_valid_q <= pipe_valid_d;
            in_flight_q  <= in_flight_d;
            count_q      <= count_d;
            occupancy_q  <= occupancy_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            error_q      <= error_d;
        end
    end

    // Storage needs no reset: out_fp_o is masked until an entry is written.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= pipe_fp_i;
    end

    assign pipe_a_o     = pipe_a_q;
    assign pipe_b_o     = pipe_b_q;
    assign pipe_valid_o = pipe_valid_q;
    assign occupancy_o  = occupancy_q;
    assign error_o      = error_q;
endmodule

// File: tb/tb_floating_point_divider_wrapper.sv
// Directed bench: DEPTH=4 and DEPTH=32 wrappers, each driving a behavioural
// 27-cycle divider pipeline; directed steps checked with immediate assertions.
module tb_floating_point_divider_wrapper;
    localparam int L = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DEPTH=4 instance signals
    logic [31:0] a4 = '0, b4 = '0, pa4, pb4, pfp4, ofp4;
    logic        v4 = 1'b0, rdy4, pv4o, pv4i, ov4, ordy4 = 1'b0, err4;
    logic [2:0]  occ4;
    logic        use_bench_pipe = 1'b0, bench_pv = 1'b0;
    logic [31:0] bench_fp = '0;

    // DEPTH=32 instance signals
    logic [31:0] a32 = '0, b32 = '0, pa32, pb32, pfp32, ofp32;
    logic        v32 = 1'b0, rdy32, pv32o, pv32i, ov32, ordy32 = 1'b0, err32;
    logic [5:0]  occ32;

    logic [31:0] p4_d [L];
    logic        p4_v [L];
    logic [31:0] p32_d [L];
    logic        p32_v [L];

    // Truncating divider model for normal operands.
    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] q;
        logic [8:0]  e;
        logic [22:0] m;
        q = {1'b1, a[22:0], 24'b0} / {24'b0, 1'b1, b[22:0]};
        if (q[24]) begin
            e = {1'b0, a[30:23]} - {1'b0, b[30:23]} + 9'd127;
            m = q[23:1];
        end else begin
            e = {1'b0, a[30:23]} - {1'b0, b[30:23]} + 9'd126;
            m = q[22:0];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                p4_v[i]  <= 1'b0;
                p32_v[i] <= 1'b0;
            end
        end else begin
            p4_v[0]  <= pv4o;
            p4_d[0]  <= fdiv(pa4, pb4);
            p32_v[0] <= pv32o;
            p32_d[0] <= fdiv(pa32, pb32);
            for (int i = 1; i < L; i++) begin
                p4_v[i]  <= p4_v[i-1];
                p4_d[i]  <= p4_d[i-1];
                p32_v[i] <= p32_v[i-1];
                p32_d[i] <= p32_d[i-1];
            end
        end
    end

    assign pv4i  = use_bench_pipe ? bench_pv : p4_v[L-1];
    assign pfp4  = use_bench_pipe ? bench_fp : p4_d[L-1];
    assign pv32i = p32_v[L-1];
    assign pfp32 = p32_d[L-1];

    floating_point_divider_wrapper #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .DEPTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_a_i(a4), .in_b_i(b4), .in_valid_i(v4),
        .in_ready_o(rdy4), .pipe_a_o(pa4), .pipe_b_o(pb4), .pipe_valid_o(pv4o),
        .pipe_fp_i(pfp4), .pipe_valid_i(pv4i), .out_fp_o(ofp4), .out_valid_o(ov4),
        .out_ready_i(ordy4), .occupancy_o(occ4), .error_o(err4)
    );

    floating_point_divider_wrapper #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .DEPTH(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .in_a_i(a32), .in_b_i(b32), .in_valid_i(v32),
        .in_ready_o(rdy32), .pipe_a_o(pa32), .pipe_b_o(pb32), .pipe_valid_o(pv32o),
        .pipe_fp_i(pfp32), .pipe_valid_i(pv32i), .out_fp_o(ofp32), .out_valid_o(ov32),
        .out_ready_i(ordy32), .occupancy_o(occ32), .error_o(err32)
    );

    // Hand-computed quotients: 6/2, 1/2, 10/4, 7/2, 12/3, 9/3, -6/2, 1/-4
    logic [31:0] vec_a [8] = '{32'h40C00000, 32'h3F800000, 32'h41200000, 32'h40E00000,
                               32'h41400000, 32'h41100000, 32'hC0C00000, 32'h3F800000};
    logic [31:0] vec_b [8] = '{32'h40000000, 32'h40000000, 32'h40800000, 32'h40000000,
                               32'h40400000, 32'h40400000, 32'h40000000, 32'hC0800000};
    logic [31:0] vec_q [8] = '{32'h40400000, 32'h3F000000, 32'h40200000, 32'h40600000,
                               32'h40800000, 32'h40400000, 32'hC0400000, 32'hBE800000};

    logic [31:0] exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int acc, issued, got, seen, first_c, last_c, gaps, drops;
        logic [31:0] opa;

        // Reset
        rst = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(rdy4), 0);
        chk("rst_pipe_valid", 32'(pv4o), 0);
        chk("rst_pipe_a", pa4, 0);
        chk("rst_pipe_b", pb4, 0);
        chk("rst_out_valid", 32'(ov4), 0);
        chk("rst_out_fp", ofp4, 0);
        chk("rst_occ", 32'(occ4), 0);
        chk("rst_err", 32'(err4), 0);
        rst = 1'b0;
        step();
        chk("rel_in_ready", 32'(rdy4), 1);

        // Single operation 6/2
        a4 = vec_a[0]; b4 = vec_b[0]; v4 = 1'b1;
        step();
        v4 = 1'b0;
        chk("single_pipe_valid", 32'(pv4o), 1);
        chk("single_pipe_a", pa4, 32'h40C00000);
        chk("single_pipe_b", pb4, 32'h40000000);
        chk("single_occ", 32'(occ4), 1);
        step();
        chk("single_pipe_valid_pulse", 32'(pv4o), 0);
        for (int i = 0; i < 26; i++) step();
        chk("single_not_early", 32'(ov4), 0);
        step();
        chk("single_out_valid", 32'(ov4), 1);
        chk("single_out_fp", ofp4, 32'h40400000);
        ordy4 = 1'b1;
        step();
        ordy4 = 1'b0;
        chk("single_occ_after_pop", 32'(occ4), 0);
        chk("single_empty", 32'(ov4), 0);

        // Fill under backpressure
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            a4 = vec_a[acc % 8]; b4 = vec_b[acc % 8]; v4 = 1'b1;
            if (rdy4) begin
                exp_q.push_back(vec_q[acc % 8]);
                acc++;
            end
            step();
        end
        v4 = 1'b0;
        chk("fill_accepted", acc, 4);
        chk("fill_ready_low", 32'(rdy4), 0);
        chk("fill_occ", 32'(occ4), 4);
        for (int i = 0; i < 30; i++) step();
        chk("fill_err", 32'(err4), 0);
        chk("fill_ready_still_low", 32'(rdy4), 0);
        ordy4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(ov4), 1);
            chk("drain_data", ofp4, exp_q.pop_front());
            step();
            if (i == 0) chk("drain_ready_after_pop", 32'(rdy4), 1);
        end
        ordy4 = 1'b0;
        chk("drain_empty", 32'(ov4), 0);
        chk("drain_occ", 32'(occ4), 0);

        // Full FIFO with interleaved pops; 10 ops wrap both pointers
        issued = 0; got = 0;
        for (int c = 0; c < 400 && got < 10; c++) begin
            v4 = (issued < 10);
            a4 = vec_a[issued % 8]; b4 = vec_b[issued % 8];
            ordy4 = (c >= 40) && (c % 3 == 0);
            if (v4 && rdy4) begin
                exp_q.push_back(vec_q[issued % 8]);
                issued++;
            end
            if (ov4 && ordy4) begin
                chk("wrap_data", ofp4, exp_q.pop_front());
                got++;
            end
            step();
        end
        v4 = 1'b0; ordy4 = 1'b0;
        chk("wrap_received", got, 10);
        chk("wrap_err", 32'(err4), 0);
        chk("wrap_occ", 32'(occ4), 0);

        // Reset mid-operation: 1 buffered, 3 in flight
        a4 = vec_a[4]; b4 = vec_b[4]; v4 = 1'b1;
        step();
        v4 = 1'b0;
        for (int i = 0; i < 30; i++) step();
        chk("mid_buffered", 32'(ov4), 1);
        for (int i = 5; i < 8; i++) begin
            a4 = vec_a[i]; b4 = vec_b[i]; v4 = 1'b1;
            step();
        end
        v4 = 1'b0;
        step();
        chk("mid_occ_before", 32'(occ4), 4);
        rst = 1'b1;
        step();
        chk("mid_rst_out_valid", 32'(ov4), 0);
        chk("mid_rst_out_fp", ofp4, 0);
        chk("mid_rst_occ", 32'(occ4), 0);
        chk("mid_rst_pipe_valid", 32'(pv4o), 0);
        chk("mid_rst_pipe_a", pa4, 0);
        chk("mid_rst_err", 32'(err4), 0);
        rst = 1'b0;
        step();
        chk("mid_ready_after", 32'(rdy4), 1);
        seen = 0;
        for (int i = 0; i < L + 2; i++) begin
            if (ov4) seen++;
            step();
        end
        chk("mid_no_stale", seen, 0);

        // Spurious result
        use_bench_pipe = 1'b1;
        bench_fp = 32'h12345678; bench_pv = 1'b1;
        step();
        bench_pv = 1'b0;
        chk("spur_err", 32'(err4), 1);
        chk("spur_out_valid", 32'(ov4), 0);
        chk("spur_occ", 32'(occ4), 0);
        for (int i = 0; i < 5; i++) step();
        chk("spur_err_sticky", 32'(err4), 1);
        chk("spur_still_empty", 32'(ov4), 0);
        use_bench_pipe = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("spur_err_cleared", 32'(err4), 0);

        // Streaming on DEPTH=32: x/2 is x with exponent minus one
        exp_q.delete();
        issued = 0; got = 0; first_c = -1; last_c = -1; gaps = 0; drops = 0;
        ordy32 = 1'b1;
        b32 = 32'h40000000;
        for (int c = 0; c < 200; c++) begin
            if (ov32) begin
                if (first_c < 0) first_c = c;
                else if (c != last_c + 1) gaps++;
                last_c = c;
                chk("stream_data", ofp32, exp_q.pop_front());
                got++;
            end
            if (issued < 100) begin
                opa = {1'b0, 8'(100 + (issued % 20)), 23'($urandom_range(0, 32'h7FFFFF))};
                a32 = opa; v32 = 1'b1;
                if (!rdy32) drops++;
                else begin
                    exp_q.push_back(opa - 32'h00800000);
                    issued++;
                end
            end else begin
                v32 = 1'b0;
            end
            step();
        end
        ordy32 = 1'b0;
        chk("stream_ready_never_low", drops, 0);
        chk("stream_received", got, 100);
        chk("stream_first_cycle", first_c, 29);
        chk("stream_consecutive", gaps, 0);
        chk("stream_err", 32'(err32), 0);
        chk("stream_occ", 32'(occ32), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
